philv_control_fsm: RTL and testbench

//  Multicycle sequencer for the Philosophy-V core datapath: memory, IR, register file, operand regs, ALU, ALU_OUT.

---
 rtl/philv_control_fsm_pkg.sv | 32 +++
 rtl/philv_control_fsm_opcode_class.sv | 26 ++
 rtl/philv_control_fsm.sv | 137 +++++++++++++
 tb/tb_philv_control_fsm.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/philv_control_fsm_pkg.sv
// Shared definitions for the Philosophy-V control sequencer.
// Contents: opcode constants, state encodings, alu_op codes and ALU operand-B select codes.
package philv_control_fsm_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_t;

  typedef enum logic [1:0] {
    B_RS2  = 2'd0,
    B_IMM  = 2'd1,
    B_FOUR = 2'd2
  } b_sel_t;

endpackage

// File: rtl/philv_control_fsm_opcode_class.sv
// Combinational opcode classifier.
// Ports: opcode in; is_r, is_i, is_ld, is_st, is_br, illegal out (one-hot or illegal).
module philv_opcode_class
  import philv_control_fsm_pkg::*;
#(
  parameter int unsigned OPCODE_WIDTH = 7
) (
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output logic                    is_r,
  output logic                    is_i,
  output logic                    is_ld,
  output logic                    is_st,
  output logic                    is_br,
  output logic                    illegal
);

  always_comb begin
    is_r    = (opcode == OPCODE_WIDTH'(OP_R));
    is_i    = (opcode == OPCODE_WIDTH'(OP_I));
    is_ld   = (opcode == OPCODE_WIDTH'(OP_LOAD));
    is_st   = (opcode == OPCODE_WIDTH'(OP_STORE));
    is_br   = (opcode == OPCODE_WIDTH'(OP_BRANCH));
    illegal = !(is_r || is_i || is_ld || is_st || is_br);
  end

endmodule

// File: rtl/philv_control_fsm.sv
// Multicycle control sequencer for the Philosophy-V core.
// Steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
// Ports:
//   inputs  clk, rst, opcode, mem_ready, alu_zero
//   outputs PC/IR/memory/operand/ALU/register-file enables and selects,
//           state (debug code), illegal_instr (sticky)
module philv_control_fsm
  import philv_control_fsm_pkg::*;
#(
  parameter int unsigned OPCODE_WIDTH = 7,
  parameter int unsigned STATE_WIDTH  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    mem_ready,
  input  logic                    alu_zero,
  output logic                    pc_ena,
  output logic                    pc_src,
  output logic                    ir_ena,
  output logic                    mem_rd,
  output logic                    mem_wr,
  output logic                    mem_addr_sel,
  output logic                    opreg_ena,
  output logic                    alu_out_ena,
  output logic [1:0]              alu_src_b_sel,
  output logic [1:0]              alu_op,
  output logic                    reg_wr_ena,
  output logic                    wb_sel,
  output logic [STATE_WIDTH-1:0]  state,
  output logic                    illegal_instr
);

  state_t state_q, state_d;
  logic   illegal_q, set_illegal;
  logic   is_r, is_i, is_ld, is_st, is_br, illegal;

  philv_opcode_class #(.OPCODE_WIDTH(OPCODE_WIDTH)) u_opcode_class (
    .opcode  (opcode),
    .is_r    (is_r),
    .is_i    (is_i),
    .is_ld   (is_ld),
    .is_st   (is_st),
    .is_br   (is_br),
    .illegal (illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (set_illegal) illegal_q <= 1'b1;
    end
  end

  // Outputs stay at their zero defaults while rst is high, so nothing strobes
  // in the reset cycle even though the state register has not yet moved.
  always_comb begin
    state_d       = state_q;
    set_illegal   = 1'b0;
    pc_ena        = 1'b0;
    pc_src        = 1'b0;
    ir_ena        = 1'b0;
    mem_rd        = 1'b0;
    mem_wr        = 1'b0;
    mem_addr_sel  = 1'b0;
    opreg_ena     = 1'b0;
    alu_out_ena   = 1'b0;
    alu_src_b_sel = B_RS2;
    alu_op        = ALU_ADD;
    reg_wr_ena    = 1'b0;
    wb_sel        = 1'b0;

    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            ir_ena  = 1'b1;
            pc_ena  = 1'b1;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          opreg_ena = 1'b1;
          if (illegal) begin
            set_illegal = 1'b1;
            state_d     = S_HALT;
          end else begin
            state_d = S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          alu_out_ena = !is_br;
          if (is_r) begin
            alu_op  = ALU_FUNCT;
            state_d = S_WRITEBACK;
          end else if (is_i) begin
            alu_op        = ALU_FUNCT;
            alu_src_b_sel = B_IMM;
            state_d       = S_WRITEBACK;
          end else if (is_ld || is_st) begin
            alu_src_b_sel = B_IMM;
            state_d       = S_MEMORY;
          end else if (is_br) begin
            alu_op  = ALU_SUB;
            pc_src  = 1'b1;
            pc_ena  = alu_zero;
            state_d = S_FETCH;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_MEMORY: begin
          mem_addr_sel = 1'b1;
          mem_rd       = is_ld;
          mem_wr       = is_st;
          if (mem_ready || !(is_ld || is_st))
            state_d = is_ld ? S_WRITEBACK : S_FETCH;
        end
        S_WRITEBACK: begin
          reg_wr_ena = 1'b1;
          wb_sel     = is_ld;
          state_d    = S_FETCH;
        end
        S_HALT: state_d = S_HALT;
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign state         = STATE_WIDTH'(state_q);
  assign illegal_instr = illegal_q;

endmodule

// File: tb/tb_philv_control_fsm.sv
module tb_philv_control_fsm;

  typedef struct packed {
    logic [2:0] st;
    logic       ill;
    logic       pce, pcs, ire, rd, wr, as, ope, aoe;
    logic [1:0] bsel, aop;
    logic       rwe, wbs;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       alu_zero = 1'b0;
  logic       pc_ena, pc_src, ir_ena, mem_rd, mem_wr, mem_addr_sel;
  logic       opreg_ena, alu_out_ena, reg_wr_ena, wb_sel, illegal_instr;
  logic [1:0] alu_src_b_sel, alu_op;
  logic [2:0] state;

  int unsigned tests = 0;
  int unsigned fails = 0;
  obs_t  sb_q[$];
  string tag_q[$];

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  philv_control_fsm #(.OPCODE_WIDTH(7), .STATE_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .alu_zero(alu_zero),
    .pc_ena(pc_ena), .pc_src(pc_src), .ir_ena(ir_ena), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr_sel(mem_addr_sel), .opreg_ena(opreg_ena), .alu_out_ena(alu_out_ena),
    .alu_src_b_sel(alu_src_b_sel), .alu_op(alu_op), .reg_wr_ena(reg_wr_ena),
    .wb_sel(wb_sel), .state(state), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  function automatic obs_t e_quiet(input logic [2:0] st, input logic ill);
    obs_t o = '0;
    o.st = st; o.ill = ill;
    return o;
  endfunction

  function automatic obs_t e_fetch(input logic mr);
    obs_t o = '0;
    o.st = 3'd0; o.rd = 1'b1; o.ire = mr; o.pce = mr;
    return o;
  endfunction

  function automatic obs_t e_dec();
    obs_t o = '0;
    o.st = 3'd1; o.ope = 1'b1;
    return o;
  endfunction

  // kind: 0 R-type, 1 I-ALU, 2 load/store
  function automatic obs_t e_exec(input int kind);
    obs_t o = '0;
    o.st = 3'd2; o.aoe = 1'b1;
    o.aop  = (kind == 2) ? 2'd0 : 2'd2;
    o.bsel = (kind == 0) ? 2'd0 : 2'd1;
    return o;
  endfunction

  function automatic obs_t e_br(input logic az);
    obs_t o = '0;
    o.st = 3'd2; o.aop = 2'd1; o.pcs = 1'b1; o.pce = az;
    return o;
  endfunction

  function automatic obs_t e_mem(input logic ld);
    obs_t o = '0;
    o.st = 3'd3; o.as = 1'b1; o.rd = ld; o.wr = !ld;
    return o;
  endfunction

  function automatic obs_t e_wb(input logic ld);
    obs_t o = '0;
    o.st = 3'd4; o.rwe = 1'b1; o.wbs = ld;
    return o;
  endfunction

  task automatic check_out();
    obs_t  exp, act;
    string t;
    exp = sb_q.pop_front();
    t   = tag_q.pop_front();
    act = '{st: state, ill: illegal_instr, pce: pc_ena, pcs: pc_src, ire: ir_ena,
            rd: mem_rd, wr: mem_wr, as: mem_addr_sel, ope: opreg_ena, aoe: alu_out_ena,
            bsel: alu_src_b_sel, aop: alu_op, rwe: reg_wr_ena, wbs: wb_sel};
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", t, act, exp);
    end
    tests++;
    assert (!(mem_rd && mem_wr)) else begin
      fails++;
      $error("FAIL %s_rdwr: observed rd=%b wr=%b expected not both 1", t, mem_rd, mem_wr);
    end
    tests++;
    assert (!reg_wr_ena || state === 3'd4) else begin
      fails++;
      $error("FAIL %s_regwr: observed reg_wr_ena=1 in state %0d expected state 4", t, state);
    end
  endtask

  task automatic cyc(input logic r, input logic [6:0] op, input logic mr, input logic az,
                     input obs_t e, input string tag);
    rst = r; opcode = op; mem_ready = mr; alu_zero = az;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    #2;
    check_out();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    cyc(1, R, 1, 0, e_quiet(3'd0, 1'b0), "reset");

    // First cycle after release: fetch waits on memory
    cyc(0, R, 0, 0, e_fetch(1'b0), "fetch_wait");
    cyc(0, R, 1, 0, e_fetch(1'b1), "r_fetch");
    cyc(0, R, 1, 0, e_dec(),       "r_decode");
    cyc(0, R, 1, 0, e_exec(0),     "r_exec");
    cyc(0, R, 1, 0, e_wb(1'b0),    "r_wb");

    cyc(0, I, 1, 0, e_fetch(1'b1), "i_fetch");
    cyc(0, I, 1, 0, e_dec(),       "i_decode");
    cyc(0, I, 1, 0, e_exec(1),     "i_exec");
    cyc(0, I, 1, 0, e_wb(1'b0),    "i_wb");

    cyc(0, LD, 1, 0, e_fetch(1'b1), "ld_fetch");
    cyc(0, LD, 1, 0, e_dec(),       "ld_decode");
    cyc(0, LD, 1, 0, e_exec(2),     "ld_exec");
    for (int i = 0; i < 3; i++)
      cyc(0, LD, 0, 0, e_mem(1'b1), $sformatf("ld_mem_wait%0d", i));
    cyc(0, LD, 1, 0, e_mem(1'b1),   "ld_mem_done");
    cyc(0, LD, 1, 0, e_wb(1'b1),    "ld_wb");

    cyc(0, ST, 1, 0, e_fetch(1'b1), "st_fetch");
    cyc(0, ST, 1, 0, e_dec(),       "st_decode");
    cyc(0, ST, 1, 0, e_exec(2),     "st_exec");
    cyc(0, ST, 1, 0, e_mem(1'b0),   "st_mem");

    cyc(0, BR, 1, 1, e_fetch(1'b1), "brt_fetch");
    cyc(0, BR, 1, 1, e_dec(),       "brt_decode");
    cyc(0, BR, 1, 1, e_br(1'b1),    "brt_exec");
    cyc(0, BR, 1, 0, e_fetch(1'b1), "brn_fetch");
    cyc(0, BR, 1, 0, e_dec(),       "brn_decode");
    cyc(0, BR, 1, 0, e_br(1'b0),    "brn_exec");

    // Store interrupted by reset while in MEMORY
    cyc(0, ST, 1, 0, e_fetch(1'b1),        "str_fetch");
    cyc(0, ST, 1, 0, e_dec(),              "str_decode");
    cyc(0, ST, 1, 0, e_exec(2),            "str_exec");
    cyc(1, ST, 1, 0, e_quiet(3'd3, 1'b0),  "str_mem_rst");
    cyc(0, ST, 0, 0, e_fetch(1'b0),        "str_after_rst");

    cyc(0, BAD, 1, 0, e_fetch(1'b1), "bad_fetch");
    cyc(0, BAD, 1, 0, e_dec(),       "bad_decode");
    for (int i = 0; i < 12; i++)
      cyc(0, BAD, 1, 1, e_quiet(3'd5, 1'b1), $sformatf("halt%0d", i));
    cyc(1, BAD, 1, 0, e_quiet(3'd5, 1'b1), "halt_rst");
    cyc(0, R, 1, 0, e_fetch(1'b1),         "halt_cleared");

    tests++;
    assert (sb_q.size() == 0) else begin
      fails++;
      $error("FAIL sb_drain: observed %0d pending expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
